rv32i_system_top: RTL and testbench



---
 rtl/rv32i_system_top_pkg.sv | 52 +++++
 rtl/rv32i_system_top_alu32.sv | 31 +++
 rtl/rv32i_system_top_core.sv | 198 +++++++++++++++++++
 rtl/rv32i_system_top.sv | 31 +++
 tb/tb_rv32i_system_top.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_system_top_pkg.sv
// Shared constants for the RV32I microcontroller: memory size, opcode map,
// ALU control codes, load/store width codes and bench result strings.
package rv32i_system_top_pkg;

  localparam int RAM_WORD_CNT = 1024;
  localparam int RAM_ADDR_W   = $clog2(RAM_WORD_CNT);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam string ASSERT_SUCCESS    = "ASSERT_SUCCESS";
  localparam string ASSERT_FAIL       = "ASSERT_FAIL";
  localparam string ASSERT_TIMEOUT    = "ASSERT_TIMEOUT";
  localparam string ASSERT_DEBUG_STOP = "ASSERT_DEBUG_STOP";

  // alt selects SUB/SRA (instr[30]) for the two funct3 codes that have a variant
  function automatic alu_op_t alu_op_decode(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_system_top_alu32.sv
// 32-bit integer ALU for OP and OP-IMM; shifts use the low 5 bits of b.
module alu32
  import rv32i_system_top_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    y = a + b;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $signed(a) >>> shamt;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end

endmodule

// File: rtl/rv32i_system_top_core.sv
// Single-cycle RV32I core (cpu), its register file and the unified RAM with
// one combinational fetch port and one combinational-read / clocked-write data port.
module register_file32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        rd_we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data
);

  logic [31:0] rf [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rd_we && rd_addr != 5'd0) begin
      rf[rd_addr] <= rd_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : rf[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : rf[rs2_addr];

endmodule

module ram
  import rv32i_system_top_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_data,
  input  logic [31:0] data_addr,
  output logic [31:0] data_rdata,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be
);

  logic [31:0] RAM [0:RAM_WORD_CNT-1];
  logic [RAM_ADDR_W-1:0] instr_idx;
  logic [RAM_ADDR_W-1:0] data_idx;
  logic unused_addr_bits;

  // Dropping the high address bits makes the byte space wrap modulo the RAM size.
  assign instr_idx  = instr_addr[RAM_ADDR_W+1:2];
  assign data_idx   = data_addr[RAM_ADDR_W+1:2];
  assign instr_data = RAM[instr_idx];
  assign data_rdata = RAM[data_idx];
  assign unused_addr_bits = ^{instr_addr[31:RAM_ADDR_W+2], instr_addr[1:0],
                              data_addr[31:RAM_ADDR_W+2], data_addr[1:0]};

  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (data_be[lane]) RAM[data_idx][lane*8 +: 8] <= data_wdata[lane*8 +: 8];
    end
  end

endmodule

module cpu
  import rv32i_system_top_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] data_rdata,
  output logic [31:0] instr_addr,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_be
);

  logic [31:0] PC, next_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data, alu_b, alu_y, rd_data, mem_addr;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic        rd_we, branch_taken;
  alu_op_t     alu_op;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) PC <= RESET_PC;
    else        PC <= next_pc;
  end

  register_file32 registerFile32Inst (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1), .rs2_addr(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_we(rd_we), .rd_addr(rd), .rd_data(rd_data)
  );

  // Only OP takes rs2 as operand; instr[30] is a real funct7 bit only for OP and shifts.
  assign alu_b  = (opcode == OPC_OP) ? rs2_data : imm_i;
  assign alu_op = alu_op_decode(funct3, (opcode == OPC_OP || funct3 == 3'b101) && instr[30]);

  alu32 alu_inst (.op(alu_op), .a(rs1_data), .b(alu_b), .y(alu_y));

  // Shared by loads, stores and the JALR target.
  assign mem_addr   = rs1_data + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign data_addr  = mem_addr;
  assign instr_addr = PC;

  always_comb begin
    case (mem_addr[1:0])
      2'd0:    load_byte = data_rdata[7:0];
      2'd1:    load_byte = data_rdata[15:8];
      2'd2:    load_byte = data_rdata[23:16];
      default: load_byte = data_rdata[31:24];
    endcase
    load_half = mem_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
  end

  always_comb begin
    case (funct3)
      3'b000:  branch_taken = (rs1_data == rs2_data);
      3'b001:  branch_taken = (rs1_data != rs2_data);
      3'b100:  branch_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  branch_taken = (rs1_data <  rs2_data);
      3'b111:  branch_taken = (rs1_data >= rs2_data);
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    rd_we      = 1'b0;
    rd_data    = alu_y;
    next_pc    = PC + 32'd4;
    data_be    = 4'b0000;
    data_wdata = rs2_data;
    case (opcode)
      OPC_LUI:   begin rd_we = 1'b1; rd_data = imm_u; end
      OPC_AUIPC: begin rd_we = 1'b1; rd_data = PC + imm_u; end
      OPC_JAL: begin
        rd_we   = 1'b1;
        rd_data = PC + 32'd4;
        next_pc = PC + imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          rd_we   = 1'b1;
          rd_data = PC + 32'd4;
          next_pc = {mem_addr[31:1], 1'b0};
        end
      end
      OPC_BRANCH: if (branch_taken) next_pc = PC + imm_b;
      OPC_LOAD: begin
        rd_we = 1'b1;
        case (funct3)
          F3_B:    rd_data = {{24{load_byte[7]}}, load_byte};
          F3_H:    rd_data = {{16{load_half[15]}}, load_half};
          F3_W:    rd_data = data_rdata;
          F3_BU:   rd_data = {24'b0, load_byte};
          F3_HU:   rd_data = {16'b0, load_half};
          default: rd_we = 1'b0;
        endcase
      end
      OPC_STORE: begin
        case (funct3)
          F3_B: begin
            data_be    = 4'b0001 << mem_addr[1:0];
            data_wdata = {4{rs2_data[7:0]}};
          end
          F3_H: begin
            data_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
            data_wdata = {2{rs2_data[15:0]}};
          end
          F3_W:    data_be = 4'b1111;
          default: data_be = 4'b0000;
        endcase
      end
      OPC_OP_IMM, OPC_OP: rd_we = 1'b1;
      // FENCE, ECALL, EBREAK and unknown opcodes only advance the PC.
      OPC_MISC_MEM, OPC_SYSTEM: rd_we = 1'b0;
      default: rd_we = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32i_system_top.sv
// RV32I microcontroller top: single-cycle core plus unified program/data RAM.
// Only clock and reset are external; the image is preloaded into ramInst.RAM.
module rv32i_system_top #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic sysClk,
  input logic sysRes
);

  logic [31:0] instrBusData;
  logic [31:0] instr_addr;
  logic [31:0] data_addr;
  logic [31:0] data_rdata;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;

  cpu #(.RESET_PC(RESET_PC)) cpuInst (
    .clk(sysClk), .rst_n(sysRes),
    .instr(instrBusData), .data_rdata(data_rdata),
    .instr_addr(instr_addr), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_be(data_be)
  );

  ram ramInst (
    .clk(sysClk),
    .instr_addr(instr_addr), .instr_data(instrBusData),
    .data_addr(data_addr), .data_rdata(data_rdata),
    .data_wdata(data_wdata), .data_be(data_be)
  );

endmodule

// File: tb/tb_rv32i_system_top.sv
// Directed programs from the test plan plus randomized ALU programs checked
// against an instruction-level register model.
module tb_rv32i_system_top;
  import rv32i_system_top_pkg::*;

  localparam logic [31:0] ECALL  = 32'h00000073;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [6:0] C_LUI = 7'b0110111, C_AUIPC = 7'b0010111, C_JALR = 7'b1100111;
  localparam logic [6:0] C_LOAD = 7'b0000011, C_IMM = 7'b0010011;

  logic sysClk = 1'b0;
  logic sysRes = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [31:0] prog [$];
  logic [31:0] m [0:31];

  rv32i_system_top dut (.sysClk(sysClk), .sysRes(sysRes));

  always #5 sysClk = ~sysClk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    return {imm[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3,
                                        input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input int rs2, input int rs1,
                                        input int f3);
    return {imm[11:5], 5'(rs2), 5'(rs1), 3'(f3), imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input int rs2, input int rs1,
                                        input int f3);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), 3'(f3), imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input int rd, input logic [6:0] op);
    return {imm, 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'b1101111};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic emit(input logic [31:0] w);
    prog.push_back(w);
  endtask

  task automatic li(input int rd, input logic [31:0] v);
    logic [31:0] up;
    up = v + 32'h800;
    emit(enc_u(up[31:12], rd, C_LUI));
    emit(enc_i(v, rd, 0, rd, C_IMM));
  endtask

  task automatic load_prog();
    sysRes = 1'b0;
    #1;
    for (int i = 0; i < RAM_WORD_CNT; i++) dut.ramInst.RAM[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.ramInst.RAM[i] = prog[i];
  endtask

  task automatic poke(input int byte_addr, input logic [31:0] w);
    dut.ramInst.RAM[byte_addr / 4] = w;
  endtask

  task automatic release_reset();
    @(negedge sysClk);
    sysRes = 1'b1;
  endtask

  function automatic logic [31:0] rf_rd(input int i);
    return dut.cpuInst.registerFile32Inst.rf[i];
  endfunction

  function automatic logic [31:0] rf_or_all();
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) acc = acc | dut.cpuInst.registerFile32Inst.rf[i];
    return acc;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic run_to_halt(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (dut.instrBusData !== ECALL && dut.instrBusData !== EBREAK && n < max_cycles) begin
      @(negedge sysClk);
      n++;
    end
    check({tag, "_halted"}, {31'b0, n < max_cycles}, 32'd1);
    check({tag, "_ecall"}, dut.instrBusData, ECALL);
  endtask

  initial begin
    logic [31:0] v, a, b, si, r, pc, w, saved0;
    logic [11:0] imm12;
    logic [19:0] imm20;
    logic [4:0]  sh;
    int kind, rd, rs1, rs2;

    // reset state
    #2 sysRes = 1'b0;
    #1;
    check("reset_pc", dut.cpuInst.PC, 32'h0);
    check("reset_rf", rf_or_all(), 32'h0);

    // basic ADDI program
    prog.delete();
    emit(enc_i(5, 0, 0, 1, C_IMM));
    emit(enc_i(-7, 1, 0, 2, C_IMM));
    emit(ECALL);
    load_prog();
    release_reset();
    run_to_halt("basic", 20);
    check("basic_x1", rf_rd(1), 32'd5);
    check("basic_x2", rf_rd(2), 32'hFFFFFFFE);
    check("basic_pc", dut.cpuInst.PC, 32'h8);

    // byte / half access
    prog.delete();
    li(1, 32'h80FF7F01);
    emit(enc_i(32'h100, 0, 0, 2, C_IMM));
    emit(enc_s(0, 1, 2, 2));
    emit(enc_i(1, 2, 0, 3, C_LOAD));
    emit(enc_i(2, 2, 0, 4, C_LOAD));
    emit(enc_i(3, 2, 4, 5, C_LOAD));
    emit(enc_i(2, 2, 1, 6, C_LOAD));
    emit(enc_i(2, 2, 5, 7, C_LOAD));
    emit(enc_i(0, 2, 0, 8, C_LOAD));
    emit(enc_i(3, 2, 2, 9, C_LOAD));
    emit(enc_i(3, 2, 1, 10, C_LOAD));
    emit(enc_i(1, 2, 1, 15, C_LOAD));
    emit(enc_i(32'hAA, 0, 0, 11, C_IMM));
    emit(enc_s(2, 11, 2, 0));
    emit(enc_i(0, 2, 2, 12, C_LOAD));
    emit(enc_s(1, 11, 2, 1));
    emit(enc_i(0, 2, 2, 13, C_LOAD));
    emit(ECALL);
    load_prog();
    release_reset();
    run_to_halt("mem", 60);
    check("lb_101",  rf_rd(3),  32'h0000007F);
    check("lb_102",  rf_rd(4),  32'hFFFFFFFF);
    check("lbu_103", rf_rd(5),  32'h00000080);
    check("lh_102",  rf_rd(6),  32'hFFFF80FF);
    check("lhu_102", rf_rd(7),  32'h000080FF);
    check("lb_100",  rf_rd(8),  32'h00000001);
    check("lw_103",  rf_rd(9),  32'h80FF7F01);
    check("lh_103",  rf_rd(10), 32'hFFFF80FF);
    check("lh_101",  rf_rd(15), 32'h00007F01);
    check("sb_102",  rf_rd(12), 32'h80AA7F01);
    check("sh_101",  rf_rd(13), 32'h80AA00AA);
    check("ram_100", dut.ramInst.RAM[64], 32'h80AA00AA);

    // control flow
    prog.delete();
    emit(enc_i(-1, 0, 0, 1, C_IMM));
    emit(enc_i(1, 0, 0, 2, C_IMM));
    emit(enc_b(8, 2, 1, 4));
    emit(enc_i(1, 0, 0, 3, C_IMM));
    emit(enc_b(8, 2, 1, 6));
    emit(enc_i(2, 0, 0, 4, C_IMM));
    emit(enc_i(32'h81, 0, 0, 5, C_IMM));
    emit(NOP);
    emit(enc_j(32'h40, 6));
    emit(EBREAK);
    load_prog();
    poke(32'h60, enc_i(0, 5, 0, 7, C_JALR));
    poke(32'h64, EBREAK);
    poke(32'h80, enc_b(8, 2, 1, 5));
    poke(32'h84, enc_i(3, 0, 0, 8, C_IMM));
    poke(32'h88, enc_b(8, 2, 1, 7));
    poke(32'h8C, enc_i(4, 0, 0, 9, C_IMM));
    poke(32'h90, enc_b(8, 2, 1, 1));
    poke(32'h94, enc_i(5, 0, 0, 10, C_IMM));
    poke(32'h98, enc_b(8, 2, 2, 0));
    poke(32'h9C, enc_i(6, 0, 0, 11, C_IMM));
    poke(32'hA0, ECALL);
    release_reset();
    run_to_halt("flow", 60);
    check("flow_pc",   dut.cpuInst.PC, 32'hA0);
    check("blt_taken", rf_rd(3), 32'h0);
    check("bltu_not",  rf_rd(4), 32'd2);
    check("jal_link",  rf_rd(6), 32'h24);
    check("jalr_link", rf_rd(7), 32'h64);
    check("bge_not",   rf_rd(8), 32'd3);
    check("bgeu_tkn",  rf_rd(9), 32'h0);
    check("bne_tkn",   rf_rd(10), 32'h0);
    check("beq_tkn",   rf_rd(11), 32'h0);

    // ALU edges
    prog.delete();
    emit(enc_u(20'h80000, 1, C_LUI));
    emit(enc_i({20'b0, 12'h404}, 1, 5, 2, C_IMM));
    emit(enc_i(4, 1, 5, 3, C_IMM));
    emit(enc_i(1, 0, 0, 5, C_IMM));
    emit(enc_u(20'h00001, 8, C_AUIPC));
    emit(enc_r(0, 5, 0, 3, 4));
    emit(enc_r(32, 5, 0, 0, 6));
    emit(enc_u(20'h12345, 7, C_LUI));
    emit(enc_i(9, 0, 0, 0, C_IMM));
    emit(ECALL);
    load_prog();
    release_reset();
    run_to_halt("alu", 40);
    check("srai",  rf_rd(2), 32'hF8000000);
    check("srli",  rf_rd(3), 32'h08000000);
    check("sltu",  rf_rd(4), 32'd1);
    check("sub",   rf_rd(6), 32'hFFFFFFFF);
    check("lui",   rf_rd(7), 32'h12345000);
    check("auipc", rf_rd(8), 32'h00001010);
    check("x0",    rf_rd(0), 32'h0);

    // EBREAK / FENCE / illegal are no-ops
    prog.delete();
    emit(EBREAK);
    emit(32'h0000000F);
    emit(32'hFFFFFFFF);
    emit(ECALL);
    load_prog();
    release_reset();
    check("ebreak_fetch", dut.instrBusData, EBREAK);
    @(negedge sysClk);
    check("ebreak_pc", dut.cpuInst.PC, 32'h4);
    repeat (2) @(negedge sysClk);
    check("nop_pc", dut.cpuInst.PC, 32'hC);
    check("nop_rf", rf_or_all(), 32'h0);
    check("nop_ram0", dut.ramInst.RAM[0], EBREAK);
    check("nop_ram2", dut.ramInst.RAM[2], 32'hFFFFFFFF);

    // reset in the middle of a loop
    prog.delete();
    emit(enc_i(1, 0, 0, 1, C_IMM));
    emit(enc_i(1, 1, 0, 1, C_IMM));
    emit(enc_j(32'hFFFFFFFC, 0));
    load_prog();
    saved0 = prog[0];
    release_reset();
    repeat (10) @(negedge sysClk);
    check("loop_x1", rf_rd(1), 32'd6);
    check("loop_pc", dut.cpuInst.PC, 32'h8);
    #2 sysRes = 1'b0;
    #1;
    check("midrst_pc", dut.cpuInst.PC, 32'h0);
    check("midrst_x1", rf_rd(1), 32'h0);
    check("midrst_ram", dut.ramInst.RAM[0], saved0);
    release_reset();
    @(negedge sysClk);
    check("restart_pc", dut.cpuInst.PC, 32'h4);
    check("restart_x1", rf_rd(1), 32'd1);

    // randomized ALU programs against the register model
    for (int round = 0; round < 3; round++) begin
      prog.delete();
      for (int i = 0; i < 32; i++) m[i] = '0;
      for (int i = 1; i < 8; i++) begin
        v = $urandom;
        li(i, v);
        m[i] = v;
      end
      for (int k = 0; k < 30; k++) begin
        kind  = $urandom_range(0, 20);
        rd    = $urandom_range(0, 7);
        rs1   = $urandom_range(0, 7);
        rs2   = $urandom_range(0, 7);
        imm12 = 12'($urandom_range(0, 4095));
        imm20 = 20'($urandom_range(0, 20'hFFFFF));
        sh    = 5'($urandom_range(0, 31));
        a  = m[rs1];
        b  = m[rs2];
        si = {{20{imm12[11]}}, imm12};
        pc = 32'(prog.size() * 4);
        case (kind)
          0:  begin w = enc_i(si, rs1, 0, rd, C_IMM); r = a + si; end
          1:  begin w = enc_i(si, rs1, 2, rd, C_IMM); r = ($signed(a) < $signed(si)) ? 1 : 0; end
          2:  begin w = enc_i(si, rs1, 3, rd, C_IMM); r = (a < si) ? 1 : 0; end
          3:  begin w = enc_i(si, rs1, 4, rd, C_IMM); r = a ^ si; end
          4:  begin w = enc_i(si, rs1, 6, rd, C_IMM); r = a | si; end
          5:  begin w = enc_i(si, rs1, 7, rd, C_IMM); r = a & si; end
          6:  begin w = enc_i({27'b0, sh}, rs1, 1, rd, C_IMM); r = a << sh; end
          7:  begin w = enc_i({27'b0, sh}, rs1, 5, rd, C_IMM); r = a >> sh; end
          8:  begin w = enc_i({20'b0, 7'h20, sh}, rs1, 5, rd, C_IMM); r = $signed(a) >>> sh; end
          9:  begin w = enc_r(0, rs2, rs1, 0, rd); r = a + b; end
          10: begin w = enc_r(32, rs2, rs1, 0, rd); r = a - b; end
          11: begin w = enc_r(0, rs2, rs1, 1, rd); r = a << b[4:0]; end
          12: begin w = enc_r(0, rs2, rs1, 2, rd); r = ($signed(a) < $signed(b)) ? 1 : 0; end
          13: begin w = enc_r(0, rs2, rs1, 3, rd); r = (a < b) ? 1 : 0; end
          14: begin w = enc_r(0, rs2, rs1, 4, rd); r = a ^ b; end
          15: begin w = enc_r(0, rs2, rs1, 5, rd); r = a >> b[4:0]; end
          16: begin w = enc_r(32, rs2, rs1, 5, rd); r = $signed(a) >>> b[4:0]; end
          17: begin w = enc_r(0, rs2, rs1, 6, rd); r = a | b; end
          18: begin w = enc_r(0, rs2, rs1, 7, rd); r = a & b; end
          19: begin w = enc_u(imm20, rd, C_LUI); r = {imm20, 12'b0}; end
          default: begin w = enc_u(imm20, rd, C_AUIPC); r = pc + {imm20, 12'b0}; end
        endcase
        emit(w);
        if (rd != 0) m[rd] = r;
      end
      emit(ECALL);
      load_prog();
      release_reset();
      run_to_halt($sformatf("rand%0d", round), 200);
      for (int i = 0; i < 8; i++) check($sformatf("rand%0d_x%0d", round, i), rf_rd(i), m[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
